i2c_reg_seq: RTL
================

Name: i2c_reg_seq

Overview:
- Transaction sequencer that sits directly upstream of the I2C master byte engine.
- Turns one host request (device address, register address, 1..MAX_BYTES data bytes, read or write) into the engine's command stream: wr_i2c / cmd / data_in.
- Follows the engine's ready / ACK / data_out handshake and returns read data plus a completion status to the host.
- Moves the bus-level command ordering out of software and into hardware.

Parameters:
- MAX_BYTES, 4: maximum data bytes per transaction; must be at least 2.
- LEN_W, $clog2(MAX_BYTES): width of req_len.
- START_CMD / STOP_CMD / READ_CMD / WRITE_CMD / RESTART_CMD, 3'b000 / 3'b001 / 3'b010 / 3'b011 / 3'b100: engine command encodings.
- TIMEOUT_CYCLES, 65535: watchdog limit, used only with the optional feature.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_rw  in  1  transaction type: 0 = write, 1 = read.
- req_dev_addr  in  7  7-bit slave address.
- req_reg_addr  in  8  slave register pointer.
- req_len  in  LEN_W  byte count minus 1.
- req_wdata  in  8*MAX_BYTES  write bytes; byte k is in [8k+7:8k].
- rsp_valid  out  1  one-cycle pulse when a transaction finishes.
- rsp_err  out  2  completion status: 00 ok, 01 address NACK, 10 data/register NACK, 11 timeout.
- rdata  out  8*MAX_BYTES  read bytes, same packing as req_wdata; unread bytes are 0.
- busy  out  1  high from request acceptance until rsp_valid.
- wr_i2c  out  1  command strobe to the engine; a registered, one-cycle pulse.
- cmd  out  3  engine command.
- data_in  out  8  engine write byte.
- ready  in  1  engine ready; high in the engine's idle and hold states.
- done_tick  in  1  engine byte-done level; monitored only.
- data_out  in  8  engine received byte.
- ACK  in  1  engine received ninth bit; 0 = slave acknowledged.

Behaviour:
- Reset values:
  - req_ready=1; busy=0; rsp_valid=0; rsp_err=00; rdata=0.
  - wr_i2c=0; cmd=START_CMD; data_in=0.
  - State=IDLE, phase=ISSUE; byte counter=0.
- Reset mid-transaction abandons the transaction with no STOP issued. The engine must be reset in the same cycle.
- Acceptance: on req_valid && req_ready, latch all req_* fields, clear rdata, and move to START. req_ready drops the next cycle.
- Step sequence:
  - Write: START, ADDR_W, REG, WDATA x(req_len+1), STOP, RESP.
  - Read: START, ADDR_W, REG, RESTART, ADDR_R, RDATA x(req_len+1), STOP, RESP.
- Each step runs three phases:
  - ISSUE: wait for ready=1, then pulse wr_i2c for one cycle with cmd and data_in valid in that same cycle.
  - WAIT_BUSY: wait for ready=0.
  - WAIT_DONE: wait for ready=1, then evaluate the step.
- The minimum step latency is 3 cycles plus the engine's bus time. wr_i2c is never asserted while ready=0.
- Command and data per step:
  - START: cmd=START_CMD.
  - RESTART: cmd=RESTART_CMD. The engine runs its own start sequence and returns to hold.
  - ADDR_W: cmd=WRITE_CMD, data_in={dev,1'b0}.
  - ADDR_R: cmd=WRITE_CMD, data_in={dev,1'b1}.
  - REG: cmd=WRITE_CMD, data_in=reg_addr.
  - WDATA byte k: cmd=WRITE_CMD, data_in=wdata byte k.
  - RDATA: cmd=READ_CMD. data_in=8'h00 to ACK, or 8'h01 to NACK; only the final byte is NACKed.
  - STOP: cmd=STOP_CMD. The step completes when ready returns in the engine's idle state.
- ACK evaluation in WAIT_DONE of write-type steps: if ACK=1, record the error and jump to STOP. The remaining bytes are skipped.
  - ADDR_W / ADDR_R NACK records 01.
  - REG / WDATA NACK records 10.
- RDATA: in WAIT_DONE, store data_out into rdata byte k; ACK is ignored.
- Byte counter wraps from req_len to 0 on leaving a data phase.
- RESP:
  - rsp_valid=1 for exactly one cycle with rsp_err and rdata stable.
  - rdata and rsp_err hold until the next acceptance.
  - Return to IDLE; req_ready=1 in the following cycle.
- req_valid outside IDLE is ignored; requests are never queued.

Optional Feature:
- Macro I2C_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog clears on every phase change and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: skip STOP, go to RESP with rsp_err=11, and clear the watchdog.
  - The host must reset the engine afterwards.
- Not defined: no counter is built, rsp_err=11 is never produced, and wait phases are unbounded.

Test Plan:
1. Write, dev=7'h50, reg=8'h10, len=1, wdata=16'hBEEF, slave ACKs everything -> wr_i2c pulses 6 times:
   - START
   - WRITE A0
   - WRITE 10
   - WRITE EF
   - WRITE BE
   - STOP
   - Then rsp_valid=1, rsp_err=00.
2. Read, dev=7'h50, reg=8'h02, len=2, slave returns 11, 22, 33 -> wr_i2c pulses 9 times:
   - START
   - WRITE A0
   - WRITE 02
   - RESTART
   - WRITE A1
   - READ data_in=00
   - READ data_in=00
   - READ data_in=01
   - STOP
   - Then rdata[23:0]=24'h332211, rsp_err=00.
3. Write, dev=7'h33, no slave present (ACK=1 on the address byte) -> next command is STOP, no REG/WDATA issued, rsp_err=01.
4. Write, len=3, slave NACKs data byte 1 -> bytes 2-3 not sent, STOP issued, rsp_err=10.
5. Assert reset=0 for one clk during a WDATA WAIT_BUSY phase -> next cycle: wr_i2c=0, busy=0, req_ready=1, rdata=0; a new request is accepted normally.
6. With I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, hold ready=0 after ADDR_W -> rsp_valid appears 100 cycles after entering WAIT_DONE with rsp_err=11. Without the macro, busy stays high indefinitely.

Source files
------------

// File: rtl/i2c_reg_seq_if.sv
// Host request/response and I2C byte-engine command signals for i2c_reg_seq.
// The sequencer connects through the master modport; the host/engine side uses slave.
interface i2c_reg_seq_if #(
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = $clog2(MAX_BYTES)
);
    // Host handshake: a request transfers on the rising edge where req_valid && req_ready;
    // req_ready is high only while idle, rsp_valid is a one-cycle completion pulse.
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_rw;
    logic [6:0]             req_dev_addr;
    logic [7:0]             req_reg_addr;
    logic [LEN_W-1:0]       req_len;
    logic [8*MAX_BYTES-1:0] req_wdata;
    logic                   rsp_valid;
    logic [1:0]             rsp_err;
    logic [8*MAX_BYTES-1:0] rdata;
    logic                   busy;
    logic                   wr_i2c;
    logic [2:0]             cmd;
    logic [7:0]             data_in;
    logic                   ready;
    logic                   done_tick;
    logic [7:0]             data_out;
    logic                   ACK;
    logic [3:0]             dbg_state;
    logic [1:0]             dbg_phase;
    logic                   dbg_done;

    modport master (
        input  req_valid, req_rw, req_dev_addr, req_reg_addr, req_len, req_wdata,
        input  ready, done_tick, data_out, ACK,
        output req_ready, rsp_valid, rsp_err, rdata, busy,
        output wr_i2c, cmd, data_in,
        output dbg_state, dbg_phase, dbg_done
    );

    modport slave (
        output req_valid, req_rw, req_dev_addr, req_reg_addr, req_len, req_wdata,
        output ready, done_tick, data_out, ACK,
        input  req_ready, rsp_valid, rsp_err, rdata, busy,
        input  wr_i2c, cmd, data_in,
        input  dbg_state, dbg_phase, dbg_done
    );
endinterface

// File: rtl/i2c_reg_seq.sv
// Register-access sequencer driving an I2C master byte engine from one host request.
// Optional watchdog (rsp_err=11 on a stuck engine) is built when I2C_SEQ_TIMEOUT_EN is defined.
module i2c_reg_seq #(
    parameter int       MAX_BYTES   = 4,
    parameter int       LEN_W       = $clog2(MAX_BYTES),
    parameter logic [2:0] START_CMD   = 3'b000,
    parameter logic [2:0] STOP_CMD    = 3'b001,
    parameter logic [2:0] READ_CMD    = 3'b010,
    parameter logic [2:0] WRITE_CMD   = 3'b011,
    parameter logic [2:0] RESTART_CMD = 3'b100
`ifdef I2C_SEQ_TIMEOUT_EN
    ,
    parameter int       TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic          clk,
    input  logic          reset,
    i2c_reg_seq_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_REG, S_WDATA,
        S_RESTART, S_ADDR_R, S_RDATA, S_STOP, S_RESP
    } state_e;

    typedef enum logic [1:0] {P_ISSUE, P_WAIT_BUSY, P_WAIT_DONE} phase_e;

    state_e                 state_q, state_d;
    phase_e                 phase_q, phase_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    logic [6:0]             dev_q, dev_d;
    logic [7:0]             reg_q, reg_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [8*MAX_BYTES-1:0] wdata_q, wdata_d;
    logic [8*MAX_BYTES-1:0] rdata_q, rdata_d;
    logic [1:0]             err_q, err_d;
    logic                   wr_i2c_q, wr_i2c_d;
    logic [2:0]             cmd_q, cmd_d;
    logic [7:0]             data_in_q, data_in_d;
    logic                   done_q, done_d;
    logic [2:0]             step_cmd;
    logic [7:0]             step_data;

    // Command and byte the current step presents to the engine.
    always_comb begin
        step_cmd  = WRITE_CMD;
        step_data = 8'h00;
        case (state_q)
            S_START:   step_cmd  = START_CMD;
            S_RESTART: step_cmd  = RESTART_CMD;
            S_STOP:    step_cmd  = STOP_CMD;
            S_ADDR_W:  step_data = {dev_q, 1'b0};
            S_ADDR_R:  step_data = {dev_q, 1'b1};
            S_REG:     step_data = reg_q;
            S_WDATA:   step_data = wdata_q[{cnt_q, 3'b000} +: 8];
            S_RDATA: begin
                step_cmd  = READ_CMD;
                step_data = (cnt_q == len_q) ? 8'h01 : 8'h00;
            end
            default: ;
        endcase
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] wdog_q, wdog_d;
    logic        wdog_hit;
    assign wdog_hit = (phase_q != P_ISSUE) && (state_q != S_IDLE) && (state_q != S_RESP)
                      && (wdog_q == TIMEOUT_LIM - 16'd1);
`else
    logic wdog_hit;
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        wr_i2c_d  = 1'b0;
        cmd_d     = cmd_q;
        data_in_d = data_in_q;
        done_d    = bus.done_tick;

        if (state_q == S_IDLE) begin
            if (bus.req_valid) begin
                rw_d    = bus.req_rw;
                dev_d   = bus.req_dev_addr;
                reg_d   = bus.req_reg_addr;
                len_d   = bus.req_len;
                wdata_d = bus.req_wdata;
                rdata_d = '0;
                err_d   = 2'b00;
                cnt_d   = '0;
                state_d = S_START;
                phase_d = P_ISSUE;
            end
        end else if (state_q == S_RESP) begin
            state_d = S_IDLE;
            phase_d = P_ISSUE;
        end else if (wdog_hit) begin
            // Stuck engine: no STOP can be trusted, report straight to the host.
            state_d = S_RESP;
            phase_d = P_ISSUE;
            err_d   = 2'b11;
            cnt_d   = '0;
        end else begin
            case (phase_q)
                P_ISSUE: begin
                    if (bus.ready) begin
                        wr_i2c_d  = 1'b1;
                        cmd_d     = step_cmd;
                        data_in_d = step_data;
                        phase_d   = P_WAIT_BUSY;
                    end
                end
                P_WAIT_BUSY: begin
                    if (!bus.ready) phase_d = P_WAIT_DONE;
                end
                default: begin
                    if (bus.ready) begin
                        phase_d = P_ISSUE;
                        case (state_q)
                            S_START:   state_d = S_ADDR_W;
                            S_RESTART: state_d = S_ADDR_R;
                            S_ADDR_W, S_ADDR_R: begin
                                if (bus.ACK) begin
                                    err_d   = 2'b01;
                                    state_d = S_STOP;
                                end else begin
                                    state_d = (state_q == S_ADDR_W) ? S_REG : S_RDATA;
                                end
                            end
                            S_REG: begin
                                if (bus.ACK) begin
                                    err_d   = 2'b10;
                                    state_d = S_STOP;
                                end else begin
                                    state_d = rw_q ? S_RESTART : S_WDATA;
                                end
                            end
                            S_WDATA: begin
                                if (bus.ACK) begin
                                    err_d   = 2'b10;
                                    state_d = S_STOP;
                                    cnt_d   = '0;
                                end else if (cnt_q == len_q) begin
                                    state_d = S_STOP;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q + LEN_W'(1);
                                end
                            end
                            S_RDATA: begin
                                rdata_d[{cnt_q, 3'b000} +: 8] = bus.data_out;
                                if (cnt_q == len_q) begin
                                    state_d = S_STOP;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q + LEN_W'(1);
                                end
                            end
                            S_STOP:  state_d = S_RESP;
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            phase_q   <= P_ISSUE;
            cnt_q     <= '0;
            rw_q      <= 1'b0;
            dev_q     <= '0;
            reg_q     <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 2'b00;
            wr_i2c_q  <= 1'b0;
            cmd_q     <= START_CMD;
            data_in_q <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            len_q     <= len_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            wr_i2c_q  <= wr_i2c_d;
            cmd_q     <= cmd_d;
            data_in_q <= data_in_d;
            done_q    <= done_d;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    // Watchdog restarts whenever the phase moves and only runs while waiting on the engine.
    always_comb begin
        wdog_d = '0;
        if (!wdog_hit && phase_d == phase_q && phase_q != P_ISSUE
            && state_q != S_IDLE && state_q != S_RESP) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end
`endif

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_err   = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.wr_i2c    = wr_i2c_q;
    assign bus.cmd       = cmd_q;
    assign bus.data_in   = data_in_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_phase = phase_q;
    assign bus.dbg_done  = done_q;
endmodule
